// File: rtl/sound_pkg.sv
// Shared sound-controller constants: divisor base lookup, LFSR fill, envelope limits.
// Latency: none (constants and a pure function).
// Backpressure: none.
package sound_pkg;

    // Divider shifts at or above this value stop the noise clock entirely.
    localparam logic [3:0]  FROZEN_SHIFT = 4'd14;

    // Envelope volume ceiling.
    localparam logic [3:0]  VOL_MAX      = 4'd15;

    // LFSR reload pattern (all ones); callers truncate to their own width.
    localparam logic [31:0] LFSR_RESET   = 32'hFFFF_FFFF;

    // Divisor base in core clocks: code 0 -> 8, otherwise 16 * code (16..112).
    function automatic logic [6:0] div_base(input logic [2:0] code);
        return (code == 3'd0) ? 7'd8 : {code, 4'b0000};
    endfunction

endpackage

// File: rtl/sound_envelope.sv
// Volume envelope (volume, step counter, saturation); shared by channels 1, 2 and 4. Macro: SOUND_CH4_ENVELOPE_EN.
// Latency: registered; vol_next_o is the value the volume register takes at the next rising edge.
// Backpressure: none; a trigger in the same cycle as a tick discards the tick.
module sound_envelope
    import sound_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       trigger_i,
    input  logic       tick_i,
    input  logic [3:0] init_i,
    input  logic       dir_i,
    input  logic [2:0] period_i,
    output logic [3:0] vol_next_o
);

    logic [3:0] vol_q, vol_d;

`ifdef SOUND_CH4_ENVELOPE_EN
    logic [2:0] cnt_q, cnt_d;

    // Trigger reloads; otherwise each tick counts down and a count of 1 (or a stale 0) steps the volume.
    always_comb begin
        vol_d = vol_q;
        cnt_d = cnt_q;
        if (trigger_i) begin
            vol_d = init_i;
            cnt_d = period_i;
        end else if (tick_i && (period_i != 3'd0)) begin
            if (cnt_q > 3'd1) begin
                cnt_d = cnt_q - 3'd1;
            end else begin
                cnt_d = period_i;
                if (dir_i && (vol_q != VOL_MAX)) begin
                    vol_d = vol_q + 4'd1;
                end else if (!dir_i && (vol_q != 4'd0)) begin
                    vol_d = vol_q - 4'd1;
                end
            end
        end
    end

    // Envelope step counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= 3'd0;
        else         cnt_q <= cnt_d;
    end
`else
    logic unused_env;
    assign unused_env = ^{tick_i, dir_i, period_i};

    // Without envelope stepping the volume is simply latched at trigger.
    always_comb begin
        vol_d = trigger_i ? init_i : vol_q;
    end
`endif

    // Volume register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) vol_q <= 4'd0;
        else         vol_q <= vol_d;
    end

    assign vol_next_o = vol_d;

endmodule

// File: rtl/sound_ctlr_ch4_noise.sv
// Channel-4 noise: divider-clocked long/short LFSR, length counter, envelope (SOUND_CH4_ENVELOPE_EN).
// Latency: all outputs registered; trigger, shift and length expiry are visible right after their edge.
// Backpressure: none; trigger wins over same-cycle length tick, envelope tick and timer expiry.
module sound_ctlr_ch4_noise
    import sound_pkg::*;
#(
    parameter int LFSR_WIDTH  = 15,
    parameter int SHORT_TAP   = 6,
    parameter int LEN_WIDTH   = 6,
    parameter int TIMER_WIDTH = 22
) (
    input  logic                 iClock,
    input  logic                 iReset,
    input  logic                 iTrigger,
    input  logic                 iLenTick,
    input  logic                 iEnvTick,
    input  logic [LEN_WIDTH-1:0] iLength,
    input  logic                 iLengthEn,
    input  logic [3:0]           iEnvInit,
    input  logic                 iEnvDir,
    input  logic [2:0]           iEnvPeriod,
    input  logic [3:0]           iShift,
    input  logic                 iShortMode,
    input  logic [2:0]           iDivCode,
    output logic [3:0]           oOut,
    output logic                 oEnabled
);

    localparam logic [LEN_WIDTH:0] LEN_FULL = {1'b1, {LEN_WIDTH{1'b0}}};
    localparam logic [LEN_WIDTH:0] LEN_ONE  = {{LEN_WIDTH{1'b0}}, 1'b1};

    logic [LFSR_WIDTH-1:0]  lfsr_q, lfsr_d, lfsr_step;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d, period;
    logic [LEN_WIDTH:0]     len_q, len_d;
    logic                   en_q, en_d;
    logic [3:0]             out_q, out_d, vol_d;
    logic                   frozen, expire, fb, len_tick, len_expire, dac_off;

    // A frozen divider loads 0 on trigger, so the noise clock stays idle until the next trigger.
    assign frozen = (iShift >= FROZEN_SHIFT);
    assign period = frozen ? '0 : (TIMER_WIDTH'(div_base(iDivCode)) << iShift);
    assign expire = !iTrigger && !frozen && (timer_q == TIMER_WIDTH'(1));

    // One LFSR step; short mode also injects feedback at SHORT_TAP, giving a 7-bit cycle.
    assign fb = lfsr_q[0] ^ lfsr_q[1];
    always_comb begin
        lfsr_step = {fb, lfsr_q[LFSR_WIDTH-1:1]};
        if (iShortMode) lfsr_step[SHORT_TAP] = fb;
    end

    // Divider countdown: reload on trigger or expiry, hold while frozen or idle.
    always_comb begin
        timer_d = timer_q;
        if (iTrigger || expire) begin
            timer_d = period;
        end else if (!frozen && (timer_q != '0)) begin
            timer_d = timer_q - TIMER_WIDTH'(1);
        end
    end

    // LFSR next state.
    always_comb begin
        lfsr_d = lfsr_q;
        if (iTrigger)    lfsr_d = LFSR_WIDTH'(LFSR_RESET);
        else if (expire) lfsr_d = lfsr_step;
    end

    assign len_tick   = !iTrigger && iLenTick && iLengthEn && (len_q != '0);
    assign len_expire = len_tick && (len_q == LEN_ONE);
    assign dac_off    = (iEnvInit == 4'd0) && !iEnvDir;

    // Length counter and enable flag; DAC off overrides everything, including trigger.
    always_comb begin
        len_d = len_q;
        en_d  = en_q;
        if (iTrigger) begin
            len_d = LEN_FULL - {1'b0, iLength};
            en_d  = 1'b1;
        end else if (len_tick) begin
            len_d = len_q - LEN_ONE;
            if (len_expire) en_d = 1'b0;
        end
        if (dac_off) en_d = 1'b0;
    end

    sound_envelope u_env (
        .clk_i      (iClock),
        .rst_ni     (iReset),
        .trigger_i  (iTrigger),
        .tick_i     (iEnvTick),
        .init_i     (iEnvInit),
        .dir_i      (iEnvDir),
        .period_i   (iEnvPeriod),
        .vol_next_o (vol_d)
    );

    // Sample is built from next-state values so it changes on the same edge as its causes.
    assign out_d = (en_d && !lfsr_d[0]) ? vol_d : 4'd0;

    // Channel state registers.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            lfsr_q  <= LFSR_WIDTH'(LFSR_RESET);
            timer_q <= '0;
            len_q   <= '0;
            en_q    <= 1'b0;
            out_q   <= 4'd0;
        end else begin
            lfsr_q  <= lfsr_d;
            timer_q <= timer_d;
            len_q   <= len_d;
            en_q    <= en_d;
            out_q   <= out_d;
        end
    end

    assign oOut     = out_q;
    assign oEnabled = en_q;

endmodule

// File: tb/tb_sound_ctlr_ch4_noise.sv
// Self-checking bench for sound_ctlr_ch4_noise against a behavioural channel model.
// Latency: model is updated at each rising edge and compared 1 time unit later.
// Backpressure: none.
module tb_sound_ctlr_ch4_noise;

`ifdef SOUND_CH4_ENVELOPE_EN
    localparam bit ENV_ON = 1'b1;
`else
    localparam bit ENV_ON = 1'b0;
`endif

    logic       iClock = 1'b0;
    logic       iReset, iTrigger, iLenTick, iEnvTick, iLengthEn, iEnvDir, iShortMode;
    logic [5:0] iLength;
    logic [3:0] iEnvInit, iShift;
    logic [2:0] iEnvPeriod, iDivCode;
    logic [3:0] oOut;
    logic       oEnabled;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural model state
    int m_lfsr, m_rem, m_len, m_vol, m_envneed;
    bit m_en, m_shifted;
    bit seq[$];

    sound_ctlr_ch4_noise dut (
        .iClock     (iClock),
        .iReset     (iReset),
        .iTrigger   (iTrigger),
        .iLenTick   (iLenTick),
        .iEnvTick   (iEnvTick),
        .iLength    (iLength),
        .iLengthEn  (iLengthEn),
        .iEnvInit   (iEnvInit),
        .iEnvDir    (iEnvDir),
        .iEnvPeriod (iEnvPeriod),
        .iShift     (iShift),
        .iShortMode (iShortMode),
        .iDivCode   (iDivCode),
        .oOut       (oOut),
        .oEnabled   (oEnabled)
    );

    always #5 iClock = ~iClock;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int model_out();
        return (m_en && ((m_lfsr & 1) == 0)) ? m_vol : 0;
    endfunction

    // Apply the channel rules for one clock edge using the inputs presented to it.
    task automatic model_edge();
        int  per;
        int  fb;
        bit  frozen;
        cyc++;
        m_shifted = 1'b0;
        if (!iReset) begin
            m_lfsr = 'h7FFF; m_rem = 0; m_len = 0; m_vol = 0; m_envneed = 0; m_en = 1'b0;
            return;
        end
        frozen = (iShift >= 4'd14);
        per = frozen ? 0 : (((int'(iDivCode) == 0) ? 8 : 16 * int'(iDivCode)) << iShift);
        if (iTrigger) begin
            m_lfsr    = 'h7FFF;
            m_rem     = per;
            m_len     = 64 - int'(iLength);
            m_vol     = int'(iEnvInit);
            m_envneed = int'(iEnvPeriod);
            m_en      = 1'b1;
        end else begin
            if (!frozen && m_rem > 0) begin
                if (m_rem == 1) begin
                    fb     = (m_lfsr ^ (m_lfsr >> 1)) & 1;
                    m_lfsr = (m_lfsr >> 1) | (fb << 14);
                    if (iShortMode) m_lfsr = (m_lfsr & ~(1 << 6)) | (fb << 6);
                    m_rem     = per;
                    m_shifted = 1'b1;
                end else begin
                    m_rem--;
                end
            end
            if (iLenTick && iLengthEn && m_len > 0) begin
                m_len--;
                if (m_len == 0) m_en = 1'b0;
            end
            if (ENV_ON && iEnvTick && iEnvPeriod != 3'd0) begin
                m_envneed--;
                if (m_envneed <= 0) begin
                    m_envneed = int'(iEnvPeriod);
                    if (iEnvDir) m_vol = (m_vol < 15) ? m_vol + 1 : 15;
                    else         m_vol = (m_vol > 0)  ? m_vol - 1 : 0;
                end
            end
        end
        if (iEnvInit == 4'd0 && !iEnvDir) m_en = 1'b0;
    endtask

    task automatic step();
        @(posedge iClock);
        model_edge();
        #1;
        check("out", int'(oOut), model_out());
        check("en", int'(oEnabled), int'(m_en));
    endtask

    task automatic trigger();
        iTrigger = 1'b1;
        step();
        iTrigger = 1'b0;
    endtask

    // Run until the modelled LFSR shows a 0 in bit 0, then freeze the divider.
    task automatic wait_low_then_freeze();
        for (int i = 0; i < 400 && ((m_lfsr & 1) != 0); i++) step();
        check("wait_lfsr_low_bound", m_lfsr & 1, 0);
        iShift = 4'd14;
    endtask

    task automatic env_tick();
        iEnvTick = 1'b1;
        step();
        iEnvTick = 1'b0;
    endtask

    task automatic len_tick();
        iLenTick = 1'b1;
        step();
        iLenTick = 1'b0;
    endtask

    initial begin
        int n;
        iReset = 1'b0; iTrigger = 1'b0; iLenTick = 1'b0; iEnvTick = 1'b0;
        iLengthEn = 1'b0; iEnvDir = 1'b0; iShortMode = 1'b0; iLength = 6'd0;
        iEnvInit = 4'd0; iShift = 4'd0; iEnvPeriod = 3'd0; iDivCode = 3'd0;

        // Reset state
        repeat (3) step();
        check("rst_out", int'(oOut), 0);
        check("rst_en", int'(oEnabled), 0);
        iReset = 1'b1;

        // Long mode, fastest divider
        iEnvInit = 4'd15; iEnvDir = 1'b1;
        repeat (5) step();
        check("pretrig_en", int'(oEnabled), 0);
        trigger();
        check("trig_en", int'(oEnabled), 1);
        check("trig_out", int'(oOut), 0);
        repeat (8 * 40) step();

        // Reset held low mid-play, then released with no trigger
        iReset = 1'b0;
        step();
        check("midrst_out", int'(oOut), 0);
        check("midrst_en", int'(oEnabled), 0);
        iReset = 1'b1;
        repeat (50) step();
        check("postrst_en", int'(oEnabled), 0);

        // Short mode: 127-step repetition of the observed noise bit
        iShortMode = 1'b1; iDivCode = 3'd1; iShift = 4'd2;
        trigger();
        seq.delete();
        for (int i = 0; i < 64 * 260 && seq.size() < 254; i++) begin
            step();
            if (m_shifted) seq.push_back(oOut != 4'd0);
        end
        check("short_steps", seq.size(), 254);
        for (int i = 0; i < 127 && i + 127 < seq.size(); i++)
            check("short_rep", int'(seq[i]), int'(seq[i + 127]));

        // Length counter: 64 - 62 = 2 ticks
        iShortMode = 1'b0; iDivCode = 3'd0; iShift = 4'd0;
        iLength = 6'd62; iLengthEn = 1'b1;
        trigger();
        repeat (3) step();
        len_tick();
        check("len_after1", int'(oEnabled), 1);
        repeat (3) step();
        len_tick();
        check("len_after2", int'(oEnabled), 0);
        repeat (20) step();
        check("len_out0", int'(oOut), 0);

        // Trigger coincident with a length tick and a timer expiry
        trigger();
        for (int i = 0; i < 100 && m_rem != 1; i++) step();
        check("wait_expiry_bound", int'(m_rem == 1), 1);
        iTrigger = 1'b1; iLenTick = 1'b1;
        step();
        iTrigger = 1'b0; iLenTick = 1'b0;
        check("coinc_en", int'(oEnabled), 1);
        check("coinc_out", int'(oOut), 0);
        repeat (150) step();
        len_tick();
        check("coinc_len1", int'(oEnabled), 1);
        len_tick();
        check("coinc_len2", int'(oEnabled), 0);

        // Envelope down from 2 with period 1
        iLengthEn = 1'b0; iEnvInit = 4'd2; iEnvDir = 1'b0; iEnvPeriod = 3'd1; iShift = 4'd0;
        trigger();
        wait_low_then_freeze();
        step();
        check("env_dn_start", int'(oOut), 2);
        env_tick();
        check("env_dn1", int'(oOut), ENV_ON ? 1 : 2);
        env_tick();
        check("env_dn2", int'(oOut), ENV_ON ? 0 : 2);
        env_tick();
        check("env_dn3", int'(oOut), ENV_ON ? 0 : 2);

        // Envelope up from 14, saturating at 15
        iEnvInit = 4'd14; iEnvDir = 1'b1; iShift = 4'd0;
        trigger();
        wait_low_then_freeze();
        step();
        check("env_up_start", int'(oOut), 14);
        env_tick();
        check("env_up1", int'(oOut), ENV_ON ? 15 : 14);
        env_tick();
        check("env_up2", int'(oOut), ENV_ON ? 15 : 14);

        // DAC off in the trigger cycle and while playing
        iEnvInit = 4'd0; iEnvDir = 1'b0; iShift = 4'd0;
        trigger();
        check("dac_trig_en", int'(oEnabled), 0);
        iEnvInit = 4'd5;
        trigger();
        check("dac_on_en", int'(oEnabled), 1);
        iEnvInit = 4'd0;
        step();
        check("dac_live_en", int'(oEnabled), 0);

        // Randomised episodes
        for (int ep = 0; ep < 30; ep++) begin
            iDivCode   = 3'($urandom_range(0, 7));
            iShift     = ($urandom_range(0, 7) == 0) ? 4'(14 + $urandom_range(0, 1))
                                                     : 4'($urandom_range(0, 3));
            iShortMode = 1'($urandom_range(0, 1));
            iLength    = 6'($urandom_range(0, 63));
            iLengthEn  = 1'($urandom_range(0, 1));
            iEnvInit   = 4'($urandom_range(0, 15));
            iEnvDir    = 1'($urandom_range(0, 1));
            iEnvPeriod = 3'($urandom_range(0, 7));
            trigger();
            n = $urandom_range(100, 400);
            for (int c = 0; c < n; c++) begin
                iLenTick = ($urandom_range(0, 15) == 0);
                iEnvTick = ($urandom_range(0, 19) == 0);
                iTrigger = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 49) == 0) iShortMode = ~iShortMode;
                iReset = ($urandom_range(0, 299) != 0);
                step();
            end
            iLenTick = 1'b0; iEnvTick = 1'b0; iTrigger = 1'b0; iReset = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
